fc_tcdm_responder: RTL
======================

FC_TCDM_RESPONDER -- requirements
Module: fc_tcdm_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1C00_0000, meaning the byte address of word 0.
REQ-002 SHALL have parameter NUM_WORDS, default 256, meaning the memory depth in 32-bit words (power of two, >=2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning extra cycles inserted before each grant (0..15).
REQ-004 SHALL have port clk_i, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, request from the initiator.
REQ-007 SHALL have port add_i, input, 32, byte address.
REQ-008 SHALL have port wen_i, input, 1, 0=write, 1=read.
REQ-009 SHALL have port wdata_i, input, 32, write data.
REQ-010 SHALL have port be_i, input, 4, byte enables.
REQ-011 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-012 SHALL have port r_valid_o, output, 1, response valid.
REQ-013 SHALL have port r_rdata_o, output, 32, read data.
REQ-014 SHALL have port r_opc_o, output, 1, response error flag.

Function
REQ-015 SHALL use an FSM with states IDLE and WAIT, where the counter wcnt is 4 bits.
REQ-016 With WAIT_CYCLES=0, gnt_o SHALL equal req_i combinationally in IDLE, and the FSM SHALL never leave IDLE.
REQ-017 With WAIT_CYCLES>0, IDLE with req_i SHALL go to WAIT with wcnt=WAIT_CYCLES, and gnt_o SHALL be 0.
REQ-018 In WAIT, wcnt SHALL decrement each cycle.
REQ-019 In WAIT, when wcnt==1 and req_i=1, gnt_o SHALL be 1 and the FSM SHALL return to IDLE.
REQ-020 In WAIT, if req_i drops, the FSM SHALL return to IDLE with no grant and no side effect.
REQ-021 The access SHALL take effect on the clock edge ending the grant cycle.
REQ-022 r_valid_o SHALL be 1 exactly one cycle after each grant, for one cycle, for both reads and writes.
REQ-023 Word index SHALL be (add_i - BASE_ADDR) >> 2, truncated to log2(NUM_WORDS) bits; add_i[1:0] SHALL be ignored.
REQ-024 A write SHALL update only the bytes whose be_i bit is 1.
REQ-025 A write with be_i=0 SHALL still be granted and answered, with no memory change.
REQ-026 A read SHALL return the full word on r_rdata_o in the r_valid_o cycle; a write response SHALL drive r_rdata_o=0.
REQ-027 Back-to-back grants SHALL be sustained at one per cycle when WAIT_CYCLES=0.
REQ-028 A read granted the cycle after a write to the same word SHALL return the written data.
REQ-029 r_rdata_o and r_opc_o SHALL hold their values while r_valid_o=0.
REQ-030 r_opc_o SHALL be 0 on every response unless REQ-037 applies.

Reset
REQ-031 While rst_ni=0 on a clock edge, the FSM SHALL enter IDLE, and wcnt, r_valid_o, r_rdata_o and r_opc_o SHALL clear to 0.
REQ-032 gnt_o SHALL be forced to 0 while rst_ni=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 A request pending when reset asserts SHALL be dropped: no grant and no response.

Configuration
REQ-035 Macro FC_TCDM_RESP_ERR_EN SHALL enable address-range checking.
REQ-036 Without the macro, out-of-range addresses SHALL alias per REQ-023, and r_opc_o SHALL be constant 0.
REQ-037 With the macro, an address outside [BASE_ADDR, BASE_ADDR+4*NUM_WORDS) SHALL still be granted, any write SHALL be suppressed, and the response SHALL carry r_opc_o=1 and r_rdata_o=32'hBADA_CCE5.

Structure
REQ-038 Package fc_tcdm_resp_pkg SHALL hold the FSM state enum, the ERR_RDATA constant 32'hBADA_CCE5 and the BE_W=4 constant.
REQ-039 Sub-module fc_tcdm_resp_mem SHALL implement the word array with byte-enable write and a registered read port.

Verification
REQ-040 Test A: WAIT_CYCLES=0; write 0xDEADBEEF, be=1111 to BASE_ADDR+8, then read it next cycle -> gnt_o same cycle each time, r_valid_o on the following cycles, read returns 0xDEADBEEF.
REQ-041 Test B: word holds 0x11223344; write 0xAABBCCDD with be=0101 -> a subsequent read returns 0x11BB33DD.
REQ-042 Test C: WAIT_CYCLES=3; req_i held high -> gnt_o rises in the 3rd cycle after req_i rises, and r_valid_o follows one cycle later; dropping req_i after 1 cycle -> no gnt_o, no r_valid_o.
REQ-043 Test D: 8 consecutive reads of addresses 0..28 at WAIT_CYCLES=0 -> 8 grants and 8 r_valid_o pulses on 8 consecutive cycles, with data in order.
REQ-044 Test E: FC_TCDM_RESP_ERR_EN defined; write to BASE_ADDR+4*NUM_WORDS -> r_opc_o=1 and r_rdata_o=0xBADACCE5, and word 0 is unchanged; without the macro the same write lands in word 0.
REQ-045 Test F: rst_ni=0 asserted in WAIT -> next cycle state is IDLE, and r_valid_o, r_rdata_o, r_opc_o and gnt_o are 0.

Source files
------------

// File: rtl/fc_tcdm_resp_pkg.sv
// Shared types and constants for the FC TCDM responder.
// Optional macro FC_TCDM_RESP_ERR_EN is consumed by fc_tcdm_responder.
package fc_tcdm_resp_pkg;
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      RSP_ZERO = 2'd0,
      RSP_MEM  = 2'd1,
      RSP_ERR  = 2'd2
   } rsp_sel_e;

   localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;
   localparam int          BE_W      = 4;
endpackage

// File: rtl/fc_tcdm_resp_mem.sv
// Word array with byte-enable write and registered read port.
// Contents are deliberately left unreset.
module fc_tcdm_resp_mem
   import fc_tcdm_resp_pkg::*;
#(
   parameter int NUM_WORDS = 256,
   parameter int AW        = $clog2(NUM_WORDS)
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic            i_re,
   input  logic [AW-1:0]   i_idx,
   input  logic [31:0]     i_wdata,
   input  logic [BE_W-1:0] i_be,
   output logic [31:0]     o_rdata
);
   logic [31:0] r_mem [NUM_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/fc_tcdm_responder.sv
// TCDM slave with optional wait states before each grant.
// Define FC_TCDM_RESP_ERR_EN to flag out-of-range accesses.
module fc_tcdm_responder
   import fc_tcdm_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
   parameter int          NUM_WORDS   = 256,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_i,
   input  logic [31:0]     add_i,
   input  logic            wen_i,
   input  logic [31:0]     wdata_i,
   input  logic [BE_W-1:0] be_i,
   output logic            gnt_o,
   output logic            r_valid_o,
   output logic [31:0]     r_rdata_o,
   output logic            r_opc_o
);
   localparam int          AW      = $clog2(NUM_WORDS);
   localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

   state_e      r_state, w_state_nxt;
   logic [3:0]  r_wcnt, w_wcnt_nxt;
   logic        w_gnt;
   logic [31:0] w_off;
   logic [AW-1:0] w_idx;
   logic        w_in_range;
   logic        w_we, w_re;
   logic        r_valid;
   rsp_sel_e    r_sel;
   logic [31:0] w_mem_rdata;

   assign w_off = add_i - BASE_ADDR;
   assign w_idx = AW'(w_off >> 2);

`ifdef FC_TCDM_RESP_ERR_EN
   localparam logic [31:0] LP_SPAN = 32'(4 * NUM_WORDS);
   assign w_in_range = (w_off < LP_SPAN);
`else
   assign w_in_range = 1'b1;
`endif

   always_comb begin
      w_gnt       = 1'b0;
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      unique case (r_state)
         ST_IDLE: begin
            if (req_i) begin
               if (WAIT_CYCLES == 0) begin
                  w_gnt = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_wcnt_nxt  = LP_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_wcnt_nxt = r_wcnt - 4'd1;
            if (!req_i) begin
               w_state_nxt = ST_IDLE;
               w_wcnt_nxt  = '0;
            end else if (r_wcnt == 4'd1) begin
               w_gnt       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (!rst_ni) w_gnt = 1'b0;
   end

   assign w_we = w_gnt & ~wen_i & w_in_range;
   assign w_re = w_gnt &  wen_i & w_in_range;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
         r_valid <= 1'b0;
         r_sel   <= RSP_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_valid <= w_gnt;
         // Response source is latched only on grant so data holds between responses
         if (w_gnt) begin
            r_sel <= !w_in_range ? RSP_ERR : (wen_i ? RSP_MEM : RSP_ZERO);
         end
      end
   end

   fc_tcdm_resp_mem #(
      .NUM_WORDS (NUM_WORDS),
      .AW        (AW)
   ) u_mem (
      .i_clk   (clk_i),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_idx   (w_idx),
      .i_wdata (wdata_i),
      .i_be    (be_i),
      .o_rdata (w_mem_rdata)
   );

   always_comb begin
      r_rdata_o = '0;
      unique case (r_sel)
         RSP_MEM: r_rdata_o = w_mem_rdata;
         RSP_ERR: r_rdata_o = ERR_RDATA;
         default: r_rdata_o = '0;
      endcase
   end

`ifdef FC_TCDM_RESP_ERR_EN
   assign r_opc_o = (r_sel == RSP_ERR);
`else
   assign r_opc_o = 1'b0;
`endif

   assign gnt_o     = w_gnt;
   assign r_valid_o = r_valid;
endmodule
